// File: rtl/wb_regfile.sv
// Writeback stage: picks the W-stage result, commits it to the 32x32 register file and
// serves two bypassed decode read ports. Optional retired-write counter under WB_COUNT_EN.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] W_ALUResult,
  input  logic [DATA_WIDTH-1:0] W_ReadData,
  input  logic [DATA_WIDTH-1:0] W_ImmExt,
  input  logic [DATA_WIDTH-1:0] W_MulOut,
  input  logic [DATA_WIDTH-1:0] W_quotient,
  input  logic [DATA_WIDTH-1:0] W_remainder,
  input  logic [ADDR_WIDTH-1:0] W_PCPlus4,
  input  logic [ADDR_WIDTH-1:0] W_PCTarget,
  input  logic [4:0]            W_Rd,
  input  logic [2:0]            W_ResultSrc,
  input  logic                  W_RegWrite,
  input  logic [4:0]            D_Rs1,
  input  logic [4:0]            D_Rs2,
  output logic [DATA_WIDTH-1:0] D_RD1,
  output logic [DATA_WIDTH-1:0] D_RD2,
  output logic [DATA_WIDTH-1:0] W_Result,
  output logic                  W_WriteEn,
  output logic [63:0]           wb_count
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // PC-derived sources are assumed to be DATA_WIDTH wide (ADDR_WIDTH == DATA_WIDTH).
  always_comb begin
    W_Result = W_ALUResult;
    case (W_ResultSrc)
      3'b000:  W_Result = W_ALUResult;
      3'b001:  W_Result = W_ReadData;
      3'b010:  W_Result = W_PCPlus4;
      3'b011:  W_Result = W_ImmExt;
      3'b100:  W_Result = W_PCTarget;
      3'b101:  W_Result = W_MulOut;
      3'b110:  W_Result = W_quotient;
      default: W_Result = W_remainder;
    endcase
  end

  // Gating by W_RegWrite first keeps an X index from reaching the storage when idle.
  assign W_WriteEn = W_RegWrite & (W_Rd != 5'd0);

  // Entry 0 is cleared by reset and never written, so x0 stays hard zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (W_WriteEn) begin
      regs[W_Rd] <= W_Result;
    end
  end

  // Write-first bypass hides the one-cycle commit latency from decode.
  assign D_RD1 = (D_Rs1 == 5'd0)                  ? '0       :
                 (W_WriteEn && (W_Rd == D_Rs1))   ? W_Result :
                                                    regs[D_Rs1];
  assign D_RD2 = (D_Rs2 == 5'd0)                  ? '0       :
                 (W_WriteEn && (W_Rd == D_Rs2))   ? W_Result :
                                                    regs[D_Rs2];

`ifdef WB_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (W_WriteEn) begin
      wb_count <= wb_count + 64'd1;
    end
  end
`else
  assign wb_count = '0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: table-driven source select plus hand-written
// reset, x0, bypass, disabled-write, X-idle and write-counter sequences.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] W_ALUResult, W_ReadData, W_ImmExt, W_MulOut;
  logic [31:0] W_quotient, W_remainder, W_PCPlus4, W_PCTarget;
  logic [4:0]  W_Rd;
  logic [2:0]  W_ResultSrc;
  logic        W_RegWrite;
  logic [4:0]  D_Rs1, D_Rs2;
  logic [31:0] D_RD1, D_RD2, W_Result;
  logic        W_WriteEn;
  logic [63:0] wb_count;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .W_ALUResult(W_ALUResult), .W_ReadData(W_ReadData), .W_ImmExt(W_ImmExt),
    .W_MulOut(W_MulOut), .W_quotient(W_quotient), .W_remainder(W_remainder),
    .W_PCPlus4(W_PCPlus4), .W_PCTarget(W_PCTarget),
    .W_Rd(W_Rd), .W_ResultSrc(W_ResultSrc), .W_RegWrite(W_RegWrite),
    .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .W_Result(W_Result), .W_WriteEn(W_WriteEn), .wb_count(wb_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [2:0]  src;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sources();
    W_ALUResult = 32'h11; W_ReadData = 32'h22; W_PCPlus4  = 32'h33; W_ImmExt    = 32'h44;
    W_PCTarget  = 32'h55; W_MulOut   = 32'h66; W_quotient = 32'h77; W_remainder = 32'h88;
  endtask

  task automatic drive_w(input logic [2:0] src, input logic [4:0] rd, input logic we);
    W_ResultSrc = src;
    W_Rd        = rd;
    W_RegWrite  = we;
  endtask

  task automatic read_ports(input logic [4:0] rs1, input logic [4:0] rs2);
    D_Rs1 = rs1;
    D_Rs2 = rs2;
    #1;
  endtask

  logic [63:0] exp_count;

  initial begin
    vecs[0] = '{3'b000, 5'd1, 32'h11};
    vecs[1] = '{3'b001, 5'd2, 32'h22};
    vecs[2] = '{3'b010, 5'd3, 32'h33};
    vecs[3] = '{3'b011, 5'd4, 32'h44};
    vecs[4] = '{3'b100, 5'd5, 32'h55};
    vecs[5] = '{3'b101, 5'd6, 32'h66};
    vecs[6] = '{3'b110, 5'd7, 32'h77};
    vecs[7] = '{3'b111, 5'd8, 32'h88};

    rst_n = 1'b0;
    set_sources();
    drive_w(3'b000, 5'd0, 1'b0);
    read_ports(5'd0, 5'd0);
    step(); step();
    rst_n = 1'b1;
    check("reset_wb_count", wb_count, 64'd0);

    // Reset clears a committed value and drops the in-flight write
    W_ALUResult = 32'h1234;
    drive_w(3'b000, 5'd5, 1'b1);
    step();
    drive_w(3'b000, 5'd5, 1'b0);
    read_ports(5'd5, 5'd0);
    check("x5_written", D_RD1, 32'h1234);
    rst_n = 1'b0;
    W_ALUResult = 32'h999;
    drive_w(3'b000, 5'd6, 1'b1);
    read_ports(5'd5, 5'd6);
    check("rst_old_contents", D_RD1, 32'h1234);
    check("rst_bypass_before_edge", D_RD2, 32'h999);
    step();
    check("rst_x5_cleared", D_RD1, 32'h0);
    check("rst_bypass_after_edge", D_RD2, 32'h999);
    W_RegWrite = 1'b0;
    #1;
    check("rst_x6_dropped", D_RD2, 32'h0);
    rst_n = 1'b1;
    check("rst_wb_count", wb_count, 64'd0);

    // Source select table
    set_sources();
    for (int i = 0; i < 8; i++) begin
      drive_w(vecs[i].src, vecs[i].rd, 1'b1);
      read_ports(vecs[i].rd, 5'd0);
      check($sformatf("result_src%0d", i), W_Result, vecs[i].exp);
      check($sformatf("write_en_src%0d", i), W_WriteEn, 1'b1);
      check($sformatf("bypass_src%0d", i), D_RD1, vecs[i].exp);
      exp_q.push_back(vecs[i].exp);
      step();
    end
    drive_w(3'b000, 5'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] e;
      read_ports(i[4:0], i[4:0]);
      e = exp_q.pop_front();
      check($sformatf("readback1_x%0d", i), D_RD1, e);
      check($sformatf("readback2_x%0d", i), D_RD2, e);
    end
    exp_count = 64'd8;
`ifdef WB_COUNT_EN
    check("count_after_table", wb_count, exp_count);
`else
    check("count_after_table", wb_count, 64'd0);
`endif

    // x0 never written
    W_ALUResult = 32'hDEADBEEF;
    drive_w(3'b000, 5'd0, 1'b1);
    read_ports(5'd0, 5'd0);
    check("x0_write_en", W_WriteEn, 1'b0);
    check("x0_result", W_Result, 32'hDEADBEEF);
    check("x0_read_before", D_RD1, 32'h0);
    step();
    check("x0_read_after", D_RD2, 32'h0);
`ifdef WB_COUNT_EN
    check("x0_count", wb_count, exp_count);
`else
    check("x0_count", wb_count, 64'd0);
`endif

    // Same-cycle bypass on both ports
    W_ALUResult = 32'hCAFE0001;
    drive_w(3'b000, 5'd7, 1'b1);
    read_ports(5'd7, 5'd7);
    check("bypass_rd1", D_RD1, 32'hCAFE0001);
    check("bypass_rd2", D_RD2, 32'hCAFE0001);
    step();
    W_RegWrite = 1'b0;
    #1;
    check("x7_committed_rd1", D_RD1, 32'hCAFE0001);
    check("x7_committed_rd2", D_RD2, 32'hCAFE0001);

    // Disabled write keeps prior value and does not bypass
    W_ALUResult = 32'hA5A5;
    drive_w(3'b000, 5'd3, 1'b1);
    step();
    W_ALUResult = 32'hFFFF;
    drive_w(3'b000, 5'd3, 1'b0);
    read_ports(5'd3, 5'd0);
    check("disabled_no_bypass", D_RD1, 32'hA5A5);
    check("disabled_write_en", W_WriteEn, 1'b0);
    step();
    check("disabled_kept", D_RD1, 32'hA5A5);

    // Unknown index/select while idle must not disturb storage
    W_Rd = 5'bx; W_ResultSrc = 3'bx; W_RegWrite = 1'b0;
    step(); step();
    drive_w(3'b000, 5'd0, 1'b0);
    read_ports(5'd1, 5'd8);
    check("xidle_x1", D_RD1, 32'h11);
    check("xidle_x8", D_RD2, 32'h88);

    // Write counter: 10 writes, 7 of them effective
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("count_cleared", wb_count, 64'd0);
    begin
      logic [4:0] rds [10];
      logic       wes [10];
      rds = '{5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 5'd4, 5'd9, 5'd5, 5'd6, 5'd7};
      wes = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 10; i++) begin
        W_ALUResult = 32'h100 + i;
        drive_w(3'b000, rds[i], wes[i]);
        step();
      end
    end
    drive_w(3'b000, 5'd0, 1'b0);
    #1;
`ifdef WB_COUNT_EN
    check("count_final", wb_count, 64'd7);
`else
    check("count_final", wb_count, 64'd0);
`endif
    read_ports(5'd9, 5'd7);
    check("count_x9_untouched", D_RD1, 32'h0);
    check("count_x7_last", D_RD2, 32'h109);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
